// File: rtl/mac_inv_pkg.sv
// Shared types and width constants for the mac_inverse_div divider.
// DATA_W sets the operand width; every other width is derived from it here.
package mac_inv_pkg;

    localparam int DATA_W = 8;
    localparam int DW2    = 2 * DATA_W;
    localparam int CNT_W  = $clog2(DW2);

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/mac_inv_div_step.sv
// One combinational restoring-division step: shift in a dividend bit and
// subtract the divisor if the widened remainder allows it.
module mac_inv_div_step
    import mac_inv_pkg::*;
(
    input  logic [DATA_W:0]   rem_in,
    input  logic              bit_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_out,
    output logic              q_bit
);

    logic [DATA_W+1:0] shifted;
    logic [DATA_W:0]   reduced;

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        shifted = {rem_in, bit_in};
        q_bit   = (shifted >= {2'b00, divisor});
        // rem_in < divisor keeps the difference below divisor, so the low bits suffice.
        reduced = shifted[DATA_W:0] - {1'b0, divisor};
        rem_out = q_bit ? reduced : shifted[DATA_W:0];
    end

endmodule

// File: rtl/mac_inverse_div.sv
// Recovers a = (d - c) / b and the remainder with a multi-cycle restoring divider.
// Define MAC_INV_RANGE_CHECK_EN to flag quotients that do not fit in DATA_W bits.
module mac_inverse_div
    import mac_inv_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DW2-1:0]    d_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] c_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DW2-1:0]    q_o,
    output logic [DATA_W-1:0] r_o,
    output logic              dz_o,
    output logic              uf_o,
    output logic              range_o
);

    state_e            state_q, state_d;
    logic [DW2-1:0]    d_q, diff_q, q_q, diff;
    logic [DATA_W-1:0] b_q, c_q, r_q;
    logic [DATA_W:0]   rem_q, rem_next;
    logic [CNT_W-1:0]  cnt_q;
    logic              dz_q, uf_q, q_bit;
    logic              accept, underflow, last_step;

    assign accept    = valid_i && ready_o;
    assign diff      = d_q - {{DATA_W{1'b0}}, c_q};
    assign underflow = d_q < {{DATA_W{1'b0}}, c_q};
    assign last_step = (cnt_q == CNT_W'(DW2 - 1));

    mac_inv_div_step u_step (
        .rem_in  (rem_q),
        .bit_in  (diff_q[DW2-1]),
        .divisor (b_q),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUB;
            SUB:     state_d = (underflow || b_q == '0) ? DONE : DIV;
            DIV:     if (last_step) state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_o = (state_q == IDLE);
        valid_o = (state_q == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            d_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            diff_q <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            dz_q   <= 1'b0;
            uf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    d_q  <= d_i;
                    b_q  <= b_i;
                    c_q  <= c_i;
                    q_q  <= '0;
                    r_q  <= '0;
                    dz_q <= 1'b0;
                    uf_q <= 1'b0;
                end
                SUB: begin
                    diff_q <= diff;
                    rem_q  <= '0;
                    cnt_q  <= '0;
                    // Underflow wins over divide-by-zero when both apply.
                    if (underflow) begin
                        uf_q <= 1'b1;
                    end else if (b_q == '0) begin
                        dz_q <= 1'b1;
                        q_q  <= '1;
                    end
                end
                DIV: begin
                    q_q    <= {q_q[DW2-2:0], q_bit};
                    rem_q  <= rem_next;
                    diff_q <= diff_q << 1;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_step) r_q <= rem_next[DATA_W-1:0];
                end
                default: ;
            endcase
        end
    end

    assign q_o  = q_q;
    assign r_o  = r_q;
    assign dz_o = dz_q;
    assign uf_o = uf_q;

`ifdef MAC_INV_RANGE_CHECK_EN
    assign range_o = valid_o && !dz_q && !uf_q && (q_q[DW2-1:DATA_W] != '0);
`else
    assign range_o = 1'b0;
`endif

endmodule
